// File: rtl/bus_xfer_pkg.sv
// rtl/bus_xfer_pkg.sv - shared state encoding and default sizes for the bus transfer controller
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRIVE = 2'd2,
    S_TURN  = 2'd3
  } xfer_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TURN  = 1;

endpackage

// File: rtl/bus_tx_fifo.sv
// rtl/bus_tx_fifo.sv - synchronous transmit FIFO with count, full/empty and head output
module bus_tx_fifo
  import bus_xfer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Guard both sides so a stray request can never corrupt the pointers.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - host-side bus transfer controller: tx FIFO, request/drive/turnaround FSM, rx capture
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TURN  = DEF_TURN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             bus_req,
  input  logic             bus_gnt,
  input  logic             bus_strobe_in,
  output logic             bus_strobe_out,
  output logic             send_data,
  output logic             rcv_data,
  output logic [WIDTH-1:0] ckt_to_bus,
  input  logic [WIDTH-1:0] data_from_bus
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int TCW = (TURN > 1) ? $clog2(TURN) : 1;

  xfer_state_t      r_state;
  xfer_state_t      w_next;
  logic [TCW-1:0]   r_turn_cnt;
  logic             w_turn_done;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;

  logic             w_send;
  logic             w_rcv;
  logic             w_req;
  logic             w_strobe;

  assign w_push = tx_valid && !w_full;
  assign w_pop  = (r_state == S_DRIVE) && bus_gnt && !w_empty;

  bus_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_turn_done = (r_turn_cnt == TCW'(TURN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_turn_cnt <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_turn_cnt <= (r_state == S_TURN && !w_turn_done) ? r_turn_cnt + TCW'(1) : '0;
      r_rx_valid <= w_rcv && bus_strobe_in;
      if (w_rcv && bus_strobe_in) begin
        r_rx_data <= data_from_bus;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_send   = 1'b0;
    w_rcv    = 1'b0;
    w_req    = 1'b0;
    w_strobe = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rcv = 1'b1;
        if (!w_empty) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        w_rcv = 1'b1;
        w_req = 1'b1;
        if (bus_gnt) begin
          w_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_send   = 1'b1;
        w_req    = 1'b1;
        w_strobe = !w_empty;
        // Leave on grant loss, or when this pop drains the last word with nothing refilling it.
        if (!bus_gnt || w_empty) begin
          w_next = S_TURN;
        end else if (w_count == CW'(1) && !w_push) begin
          w_next = S_TURN;
        end
      end
      S_TURN: begin
        if (w_turn_done) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign tx_ready       = !w_full;
  assign send_data      = w_send;
  assign rcv_data       = w_rcv;
  assign bus_req        = w_req;
  assign bus_strobe_out = w_strobe;
  assign ckt_to_bus     = w_head;
  assign rx_data        = r_rx_data;
  assign rx_valid       = r_rx_valid;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_strobe_in;
  logic        bus_strobe_out;
  logic        send_data;
  logic        rcv_data;
  logic [31:0] ckt_to_bus;
  logic [31:0] data_from_bus;

  int n_tests;
  int n_fail;

  bus_xfer_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .bus_req        (bus_req),
    .bus_gnt        (bus_gnt),
    .bus_strobe_in  (bus_strobe_in),
    .bus_strobe_out (bus_strobe_out),
    .send_data      (send_data),
    .rcv_data       (rcv_data),
    .ckt_to_bus     (ckt_to_bus),
    .data_from_bus  (data_from_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    tx_data       = '0;
    tx_valid      = 1'b0;
    bus_gnt       = 1'b0;
    bus_strobe_in = 1'b0;
    data_from_bus = '0;

    tick;
    tick;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rcv_data", rcv_data, 1);
    chk("rst_send_data", send_data, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_strobe_out", bus_strobe_out, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b1;
    tick;

    // Burst of three with grant held high
    bus_gnt  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 32'hA1;
    tick;
    chk("burst_idle_req", bus_req, 0);
    tx_data = 32'hB2;
    tick;
    chk("burst_req", bus_req, 1);
    chk("burst_req_send", send_data, 0);
    tx_data = 32'hC3;
    tick;
    tx_valid = 1'b0;
    chk("burst_send0", send_data, 1);
    chk("burst_rcv0", rcv_data, 0);
    chk("burst_w0", ckt_to_bus, 32'hA1);
    chk("burst_stb0", bus_strobe_out, 1);
    tick;
    chk("burst_w1", ckt_to_bus, 32'hB2);
    chk("burst_stb1", bus_strobe_out, 1);
    tick;
    chk("burst_w2", ckt_to_bus, 32'hC3);
    chk("burst_stb2", bus_strobe_out, 1);
    tick;
    chk("burst_turn_send", send_data, 0);
    chk("burst_turn_rcv", rcv_data, 0);
    chk("burst_turn_req", bus_req, 0);
    tick;
    chk("burst_idle_rcv", rcv_data, 1);
    chk("burst_idle_req2", bus_req, 0);

    // Fill the FIFO with grant withheld
    bus_gnt  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 32'h10;
    tick;
    tx_data = 32'h11;
    tick;
    tx_data = 32'h12;
    tick;
    chk("full_ready3", tx_ready, 1);
    tx_data = 32'h13;
    tick;
    chk("full_ready0", tx_ready, 0);
    chk("full_req", bus_req, 1);
    tx_data = 32'h14;
    tick;
    chk("full_held_ready", tx_ready, 0);
    chk("full_held_send", send_data, 0);
    bus_gnt = 1'b1;
    tick;
    chk("full_drive", send_data, 1);
    chk("full_w0", ckt_to_bus, 32'h10);
    chk("full_ready_drive", tx_ready, 0);
    tick;
    chk("full_w1", ckt_to_bus, 32'h11);
    chk("full_ready_rise", tx_ready, 1);
    tick;
    tx_valid = 1'b0;
    chk("full_w2", ckt_to_bus, 32'h12);
    tick;
    chk("full_w3", ckt_to_bus, 32'h13);
    tick;
    chk("full_w4", ckt_to_bus, 32'h14);
    chk("full_w4_stb", bus_strobe_out, 1);
    tick;
    chk("full_turn", send_data, 0);
    tick;
    chk("full_idle", rcv_data, 1);

    // Grant lost while the third word is on the bus
    bus_gnt  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 32'h21;
    tick;
    tx_data = 32'h22;
    tick;
    tx_data = 32'h23;
    tick;
    tx_data = 32'h24;
    tick;
    tx_valid = 1'b0;
    bus_gnt  = 1'b1;
    tick;
    chk("gl_w1", ckt_to_bus, 32'h21);
    tick;
    chk("gl_w2", ckt_to_bus, 32'h22);
    tick;
    bus_gnt = 1'b0;
    chk("gl_w3", ckt_to_bus, 32'h23);
    chk("gl_w3_stb", bus_strobe_out, 1);
    tick;
    chk("gl_turn_send", send_data, 0);
    chk("gl_turn_req", bus_req, 0);
    tick;
    chk("gl_idle_req", bus_req, 0);
    chk("gl_idle_rcv", rcv_data, 1);
    tick;
    chk("gl_rereq", bus_req, 1);
    chk("gl_rereq_send", send_data, 0);
    bus_gnt = 1'b1;
    tick;
    chk("gl_resend_w3", ckt_to_bus, 32'h23);
    chk("gl_resend_send", send_data, 1);
    tick;
    chk("gl_resend_w4", ckt_to_bus, 32'h24);
    tick;
    chk("gl_end_turn", send_data, 0);
    tick;

    // Receive in IDLE, then ignored during DRIVE
    bus_strobe_in = 1'b1;
    data_from_bus = 32'hDEADBEEF;
    tick;
    bus_strobe_in = 1'b0;
    chk("rx_data", rx_data, 32'hDEADBEEF);
    chk("rx_valid_pulse", rx_valid, 1);
    tick;
    chk("rx_valid_drop", rx_valid, 0);
    chk("rx_data_hold", rx_data, 32'hDEADBEEF);
    tx_valid = 1'b1;
    tx_data  = 32'h55;
    tick;
    tx_valid = 1'b0;
    tick;
    tick;
    chk("rx_drv_send", send_data, 1);
    bus_strobe_in = 1'b1;
    data_from_bus = 32'h12345678;
    tick;
    bus_strobe_in = 1'b0;
    chk("rx_drv_valid", rx_valid, 0);
    chk("rx_drv_data", rx_data, 32'hDEADBEEF);
    tick;

    // Concurrent push and pop in DRIVE
    bus_gnt  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 32'h31;
    tick;
    tx_data = 32'h32;
    tick;
    tx_valid = 1'b0;
    bus_gnt  = 1'b1;
    tick;
    chk("cc_w0", ckt_to_bus, 32'h31);
    chk("cc_count0", dut.w_count, 2);
    tx_valid = 1'b1;
    tx_data  = 32'h33;
    tick;
    chk("cc_count1", dut.w_count, 2);
    chk("cc_send1", send_data, 1);
    chk("cc_w1", ckt_to_bus, 32'h32);
    tx_data = 32'h34;
    tick;
    tx_valid = 1'b0;
    chk("cc_count2", dut.w_count, 2);
    chk("cc_w2", ckt_to_bus, 32'h33);
    tick;
    chk("cc_w3", ckt_to_bus, 32'h34);
    chk("cc_send3", send_data, 1);
    tick;
    chk("cc_turn", send_data, 0);
    tick;

    // Asynchronous reset in the middle of DRIVE with three words queued
    bus_gnt  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 32'h41;
    tick;
    tx_data = 32'h42;
    tick;
    tx_data = 32'h43;
    tick;
    tx_valid = 1'b0;
    bus_gnt  = 1'b1;
    tick;
    chk("ar_drive", send_data, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_send", send_data, 0);
    chk("ar_rcv", rcv_data, 1);
    chk("ar_req", bus_req, 0);
    chk("ar_ready", tx_ready, 1);
    chk("ar_stb", bus_strobe_out, 0);
    tick;
    reset   = 1'b1;
    bus_gnt = 1'b0;
    tick;
    chk("ar_idle_req", bus_req, 0);
    chk("ar_idle_rcv", rcv_data, 1);
    tick;
    chk("ar_idle_req2", bus_req, 0);
    chk("ar_idle_send", send_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
